// File: rtl/arb_pkg.sv
// Shared definitions for the shared-register arbiter.
//   arb_state_e : FSM state encoding (IDLE, GRANT, RELEASE)
//   clog2       : index width helper, never returns less than 1 bit
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_e;

    // Width needed to index 'value' entries; at least 1 so single-entry counters stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req      : request vector, bit i = requester i
//   last_ptr : index of the previous winner; search starts one above it
//   winner   : first requesting index found, wrapping N_REQ-1 -> 0
//   valid    : high when any request bit is set
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    logic [31:0] idx;

    // Wrap is done by compare-and-subtract so non-power-of-2 N_REQ indexes correctly.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = 32'(last_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!valid && req[idx[PTR_W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared register.
// Exactly one requester (the holder) may write the register at a time.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   req     : request vector, bit i = requester i
//   wr_en   : write strobes, only the holder's strobe is honoured
//   wdata   : packed write data, slice i = requester i
//   gnt     : registered one-hot grant, zero when nobody holds the register
//   reg_q   : shared register contents
//   busy    : high while a grant is active
//   expired : high during the last grant cycle when the grant ends on the hold limit
module shared_reg_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        wr_en,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]       reg_q,
    output logic                    busy,
    output logic                    expired
);

    localparam int unsigned PTR_W  = clog2(N_REQ);
    localparam int unsigned HOLD_W = clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]    last_ptr_q, last_ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]   reg_data_q;

    logic [DATA_W-1:0]   wdata_arr [N_REQ];
    logic [PTR_W-1:0]    pick_winner;
    logic                pick_valid;
    logic                holder_req;
    logic                holder_wr;
    logic                hold_last;

    for (genvar i = 0; i < N_REQ; i++) begin : g_wdata
        assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .winner   (pick_winner),
        .valid    (pick_valid)
    );

    // last_ptr doubles as the holder index while in GRANT.
    assign holder_req = req[last_ptr_q];
    assign holder_wr  = (state_q == GRANT) && gnt_q[last_ptr_q] && wr_en[last_ptr_q];
    assign hold_last  = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;
        expired    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    state_d    = GRANT;
                    gnt_d      = N_REQ'(1) << pick_winner;
                    last_ptr_d = pick_winner;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                // A dropped request wins over the hold limit, so expired stays low then.
                if (!holder_req) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end else if (hold_last) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    expired = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RELEASE: begin
                // One dead cycle on the register bus before re-arbitration.
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
        end
    end

    // Resets to the top index so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ptr_q <= PTR_W'(N_REQ - 1);
        end else begin
            last_ptr_q <= last_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_data_q <= '0;
        end else if (holder_wr) begin
            reg_data_q <= wdata_arr[last_ptr_q];
        end
    end

    assign gnt   = gnt_q;
    assign reg_q = reg_data_q;
    assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MH = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req   = '0;
    logic [N-1:0]    wr_en = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   reg_q;
    logic            busy;
    logic            expired;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the register, for how long, and the turnaround gap.
    int            m_holder = -1;
    int            m_held   = 0;
    int            m_gap    = 0;
    int            m_last   = N - 1;
    logic [DW-1:0] m_reg    = '0;

    shared_reg_arbiter #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .gnt     (gnt),
        .reg_q   (reg_q),
        .busy    (busy),
        .expired (expired)
    );

    always #5 clk = ~clk;

    function logic [N-1:0] m_gnt();
        return (m_holder >= 0) ? N'(1 << m_holder) : '0;
    endfunction

    function logic m_expired();
        return (m_holder >= 0) && req[m_holder] && (m_held == MH - 1);
    endfunction

    function int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task model_reset();
        m_holder = -1; m_held = 0; m_gap = 0; m_last = N - 1; m_reg = '0;
    endtask

    task model_edge();
        if (m_holder >= 0) begin
            if (wr_en[m_holder]) m_reg = wdata[m_holder*DW +: DW];
            m_held++;
            if (!req[m_holder] || m_held == MH) begin
                m_holder = -1;
                m_gap    = 1;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else begin
            for (int off = 1; off <= N; off++) begin
                int idx;
                idx = (m_last + off) % N;
                if (req[idx]) begin
                    m_holder = idx; m_last = idx; m_held = 0;
                    break;
                end
            end
        end
    endtask

    task drive(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N*DW-1:0] d);
        req = r; wr_en = w; wdata = d;
        #1;
    endtask

    task tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task do_reset();
        rst_n = 1'b0; req = '0; wr_en = '0; wdata = '0;
        #1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_reset();
        do_reset();
        drive('0, '0, '0);
        n_checks++;
        if ({gnt, busy, expired, reg_q} !== {4'b0000, 1'b0, 1'b0, 8'h00}) begin
            $display("FAIL reset_state: gnt=%b busy=%b expired=%b reg_q=%h, expected all zero",
                     gnt, busy, expired, reg_q);
            n_fail++;
        end
    endtask

    task test_single();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 4) drive(4'b0100, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
            else       drive('0, '0, '0);
            n_checks++;
            if (gnt !== m_gnt() || busy !== (m_holder >= 0) || expired !== m_expired() || reg_q !== m_reg) begin
                $display("FAIL single cyc %0d: gnt=%b busy=%b exp=%b reg=%h, expected gnt=%b busy=%b exp=%b reg=%h",
                         c, gnt, busy, expired, reg_q, m_gnt(), m_holder >= 0, m_expired(), m_reg);
                n_fail++;
            end
            if (c == 0 || c == 1) begin
                n_checks++;
                if (gnt !== ((c == 1) ? 4'b0100 : 4'b0000)) begin
                    $display("FAIL single_latency cyc %0d: gnt=%b", c, gnt);
                    n_fail++;
                end
            end
            if (c == 2) begin
                n_checks++;
                if (reg_q !== 8'hA5) begin
                    $display("FAIL single_write: reg_q=%h, expected a5", reg_q);
                    n_fail++;
                end
            end
            tick();
        end
    endtask

    task test_round_robin();
        int order[$];
        int lens[$];
        int gaps[$];
        int run, gap, n_exp;
        logic [N-1:0] prev;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        run = 0; gap = 0; n_exp = 0; prev = '0;
        do_reset();
        for (int c = 0; c < 31; c++) begin
            drive(4'b1111, '0, '0);
            n_checks++;
            if (gnt !== m_gnt() || busy !== (m_holder >= 0) || expired !== m_expired() || reg_q !== m_reg) begin
                $display("FAIL rr cyc %0d: gnt=%b busy=%b exp=%b reg=%h, expected gnt=%b busy=%b exp=%b reg=%h",
                         c, gnt, busy, expired, reg_q, m_gnt(), m_holder >= 0, m_expired(), m_reg);
                n_fail++;
            end
            if (expired === 1'b1) n_exp++;
            if (gnt != 0 && prev == 0) begin
                order.push_back(onehot_idx(gnt));
                if (order.size() > 1) gaps.push_back(gap);
                run = 0;
            end
            if (gnt != 0) run++;
            if (gnt == 0 && prev != 0) begin lens.push_back(run); gap = 0; end
            if (gnt == 0) gap++;
            prev = gnt;
            tick();
        end
        n_checks++;
        if (order.size() != 5) begin
            $display("FAIL rr_count: grants=%0d, expected 5", order.size());
            n_fail++;
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (order[i] != exp_order[i]) begin
                    $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, order[i], exp_order[i]);
                    n_fail++;
                end
            end
        end
        foreach (lens[i]) begin
            n_checks++;
            if (lens[i] != MH) begin
                $display("FAIL rr_len[%0d]: got %0d, expected %0d", i, lens[i], MH);
                n_fail++;
            end
        end
        foreach (gaps[i]) begin
            n_checks++;
            if (gaps[i] != 2) begin
                $display("FAIL rr_gap[%0d]: got %0d, expected 2", i, gaps[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (n_exp != 5) begin
            $display("FAIL rr_expired: pulses=%0d, expected 5", n_exp);
            n_fail++;
        end
        for (int c = 0; c < 3; c++) begin drive('0, '0, '0); tick(); end
    endtask

    task test_wrap_skip();
        int order[$];
        logic [N-1:0] prev;
        logic bad;
        prev = '0; bad = 1'b0;
        do_reset();
        drive(4'b1000, '0, '0);
        tick();
        n_checks++;
        if (gnt !== 4'b1000) begin
            $display("FAIL wrap_setup: gnt=%b, expected 1000", gnt);
            n_fail++;
        end
        prev = gnt;
        for (int c = 1; c < 20; c++) begin
            drive(4'b0101, '0, '0);
            n_checks++;
            if (gnt !== m_gnt() || busy !== (m_holder >= 0) || expired !== m_expired() || reg_q !== m_reg) begin
                $display("FAIL wrap cyc %0d: gnt=%b busy=%b exp=%b reg=%h, expected gnt=%b busy=%b exp=%b reg=%h",
                         c, gnt, busy, expired, reg_q, m_gnt(), m_holder >= 0, m_expired(), m_reg);
                n_fail++;
            end
            if (c > 1 && (gnt[1] || gnt[3])) bad = 1'b1;
            if (gnt != 0 && prev == 0) order.push_back(onehot_idx(gnt));
            prev = gnt;
            tick();
        end
        n_checks++;
        if (order.size() < 2 || order[0] != 0 || order[1] != 2) begin
            $display("FAIL wrap_order: first=%0d second=%0d, expected 0 then 2",
                     order.size() > 0 ? order[0] : -1, order.size() > 1 ? order[1] : -1);
            n_fail++;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            $display("FAIL wrap_skip: requester 1 or 3 granted, got 1 expected 0");
            n_fail++;
        end
        for (int c = 0; c < 6; c++) begin drive('0, '0, '0); tick(); end
    endtask

    task test_isolation();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0:       drive(4'b0010, '0, '0);
                1:       drive(4'b0010, 4'b1010, {8'hFF, 8'h00, 8'h3C, 8'h5A});
                2:       drive(4'b0010, 4'b1000, {8'hEE, 8'h11, 8'h22, 8'h33});
                default: drive('0, '0, '0);
            endcase
            n_checks++;
            if (gnt !== m_gnt() || busy !== (m_holder >= 0) || expired !== m_expired() || reg_q !== m_reg) begin
                $display("FAIL iso cyc %0d: gnt=%b busy=%b exp=%b reg=%h, expected gnt=%b busy=%b exp=%b reg=%h",
                         c, gnt, busy, expired, reg_q, m_gnt(), m_holder >= 0, m_expired(), m_reg);
                n_fail++;
            end
            if (c == 2 || c == 3) begin
                n_checks++;
                if (reg_q !== 8'h3C) begin
                    $display("FAIL iso_reg cyc %0d: reg_q=%h, expected 3c", c, reg_q);
                    n_fail++;
                end
            end
            tick();
        end
    endtask

    task test_early_release();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive((c < 2) ? 4'b0011 : 4'b0010, '0, '0);
            n_checks++;
            if (gnt !== m_gnt() || busy !== (m_holder >= 0) || expired !== m_expired() || reg_q !== m_reg) begin
                $display("FAIL early cyc %0d: gnt=%b busy=%b exp=%b reg=%h, expected gnt=%b busy=%b exp=%b reg=%h",
                         c, gnt, busy, expired, reg_q, m_gnt(), m_holder >= 0, m_expired(), m_reg);
                n_fail++;
            end
            n_checks++;
            if ($countones(gnt) > 1) begin
                $display("FAIL early_onehot cyc %0d: gnt=%b", c, gnt);
                n_fail++;
            end
            if (c == 2) begin
                n_checks++;
                if (expired !== 1'b0 || gnt !== 4'b0001) begin
                    $display("FAIL early_drop: gnt=%b expired=%b, expected 0001 and 0", gnt, expired);
                    n_fail++;
                end
            end
            if (c == 5) begin
                n_checks++;
                if (gnt !== 4'b0010) begin
                    $display("FAIL early_next: gnt=%b, expected 0010", gnt);
                    n_fail++;
                end
            end
            tick();
        end
        for (int c = 0; c < 6; c++) begin drive('0, '0, '0); tick(); end
    endtask

    task test_reset_mid_grant();
        do_reset();
        drive(4'b0001, 4'b0001, {24'h0, 8'h77});
        tick();
        drive(4'b0001, 4'b0001, {24'h0, 8'h77});
        tick();
        drive(4'b0001, 4'b0001, {24'h0, 8'h99});
        n_checks++;
        if (gnt !== 4'b0001 || reg_q !== 8'h77) begin
            $display("FAIL midrst_setup: gnt=%b reg_q=%h, expected 0001 and 77", gnt, reg_q);
            n_fail++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, busy, expired, reg_q} !== {4'b0000, 1'b0, 1'b0, 8'h00}) begin
            $display("FAIL midrst: gnt=%b busy=%b expired=%b reg_q=%h, expected all zero",
                     gnt, busy, expired, reg_q);
            n_fail++;
        end
        model_reset();
        req = '0; wr_en = '0; wdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive('0, '0, '0);
        n_checks++;
        if (reg_q !== 8'h00 || gnt !== 4'b0000) begin
            $display("FAIL midrst_after: gnt=%b reg_q=%h, expected 0000 and 00", gnt, reg_q);
            n_fail++;
        end
    endtask

    task test_random();
        logic [N-1:0] r;
        r = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 4) == 0) r = N'($urandom);
            drive(r, N'($urandom), (N*DW)'($urandom));
            n_checks++;
            if (gnt !== m_gnt() || busy !== (m_holder >= 0) || expired !== m_expired() || reg_q !== m_reg) begin
                $display("FAIL rand cyc %0d: gnt=%b busy=%b exp=%b reg=%h, expected gnt=%b busy=%b exp=%b reg=%h",
                         c, gnt, busy, expired, reg_q, m_gnt(), m_holder >= 0, m_expired(), m_reg);
                n_fail++;
            end
            tick();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_isolation();
        test_early_release();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
